// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator.
// Owns the h/v/field counters, decodes sync, valid and start windows from
// parameters, and delays the decoded timing by DELAY pixel strobes so it
// lines up with the RGB pipeline. hcount/vcount are the raw counters.
module video_timing_gen #(
  parameter int H_W               = 6,
  parameter int V_W               = 9,
  parameter int H_PERIOD          = 64,
  parameter int H_SYNC_BEGIN      = 56,
  parameter int H_SYNC_END        = 61,
  parameter int H_VALID_BEGIN     = 3,
  parameter int H_VALID_END       = 53,
  parameter int V_PERIOD          = 260,
  parameter int V_SYNC_BEGIN      = 251,
  parameter int V_SYNC_END        = 254,
  parameter int V_VALID_BEGIN     = 8,
  parameter int V_VALID_END       = 248,
  parameter int HSYNC_ACTIVE_HIGH = 0,
  parameter int VSYNC_ACTIVE_HIGH = 0,
  parameter int DELAY             = 0,
  parameter int INTERLACE         = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  output logic [H_W-1:0] hcount,
  output logic [V_W-1:0] vcount,
  output logic           hsync,
  output logic           vsync,
  output logic           blank_n,
  output logic           line_start,
  output logic           frame_start,
  output logic           field
);

  // Timing word layout: {hsync, vsync, blank_n, line_start, frame_start, field}
  localparam int NB = 6;
  localparam logic [NB-1:0] IDLE = {(HSYNC_ACTIVE_HIGH == 0), (VSYNC_ACTIVE_HIGH == 0), 4'b0000};

  generate
    if ((H_PERIOD < 1) || ((H_PERIOD - 1) >= (1 << H_W))) begin : g_bad_h_w
      $error("H_W cannot hold H_PERIOD-1");
    end
    if ((V_PERIOD < 1) || (V_PERIOD >= (1 << V_W))) begin : g_bad_v_w
      $error("V_W cannot hold V_PERIOD");
    end
    if ((DELAY < 0) || (DELAY > 15)) begin : g_bad_delay
      $error("DELAY must be in 0..15");
    end
  endgenerate

  // Half-open window; an empty or inverted window is never active.
  function automatic logic in_window(input logic [31:0] c, input logic [31:0] b,
                                     input logic [31:0] e);
    return (c >= b) && (c < e);
  endfunction

  // Map an "active" condition onto the configured output level.
  function automatic logic apply_pol(input logic act, input int active_high);
    return (active_high != 0) ? act : ~act;
  endfunction

  logic [H_W-1:0] r_h;
  logic [V_W-1:0] r_v;
  logic           r_field;
  logic           w_h_last;
  logic [V_W-1:0] w_v_last;
  logic [31:0]    w_h32;
  logic [31:0]    w_v32;
  logic [NB-1:0]  w_dec;
  logic [NB-1:0]  r_stage_p [0:DELAY];

  assign w_h_last = (r_h == H_W'(H_PERIOD - 1));

  // Last line of the current field; the odd field is one line longer when interlaced.
  always_comb begin
    w_v_last = V_W'(V_PERIOD - 1);
    if ((INTERLACE != 0) && r_field) w_v_last = V_W'(V_PERIOD);
  end

  // Raster counters and field flag, advancing one pixel per strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h     <= '0;
      r_v     <= '0;
      r_field <= 1'b0;
    end else if (pix_en) begin
      if (w_h_last) begin
        r_h <= '0;
        if (r_v == w_v_last) begin
          r_v <= '0;
          if (INTERLACE != 0) r_field <= ~r_field;
        end else begin
          r_v <= r_v + 1'b1;
        end
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Combinational decode of the current counter position into a timing word.
  always_comb begin
    w_h32 = 32'(r_h);
    w_v32 = 32'(r_v);
    w_dec = {apply_pol(in_window(w_h32, H_SYNC_BEGIN, H_SYNC_END), HSYNC_ACTIVE_HIGH),
             apply_pol(in_window(w_v32, V_SYNC_BEGIN, V_SYNC_END), VSYNC_ACTIVE_HIGH),
             in_window(w_h32, H_VALID_BEGIN, H_VALID_END) &&
               in_window(w_v32, V_VALID_BEGIN, V_VALID_END),
             (r_h == '0),
             (r_h == '0) && (r_v == '0),
             r_field};
  end

  // Stage 0 registers the decode; stages 1..DELAY form the pixel-strobe delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DELAY; i++) r_stage_p[i] <= IDLE;
    end else if (pix_en) begin
      r_stage_p[0] <= w_dec;
      for (int i = 1; i <= DELAY; i++) r_stage_p[i] <= r_stage_p[i-1];
    end
  end

  assign hcount = r_h;
  assign vcount = r_v;
  assign {hsync, vsync, blank_n, line_start, frame_start, field} = r_stage_p[DELAY];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: four instances with different configurations,
// a raster model computed from the pixel index, and directed literal checks.
module tb_video_timing_gen;

  typedef struct packed {
    int hp, hsb, hse, hvb, hve, vp, vsb, vse, vvb, vve, hah, vah, dly, il;
  } cfg_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pe  = 4'b0000;
  logic       chk_en = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         k [4] = '{0, 0, 0, 0};
  cfg_t       cfgs [4];

  logic [5:0] hc0;
  logic [8:0] vc0;
  logic [2:0] hc1, hc2, hc3, vc1, vc2, vc3;
  logic [3:0] hs, vs, bl, ls, fs, fd;
  logic [31:0] hcnt [4];
  logic [31:0] vcnt [4];

  always #5 clk = ~clk;

  video_timing_gen u0 (
    .clk(clk), .rst(rst), .pix_en(pe[0]), .hcount(hc0), .vcount(vc0),
    .hsync(hs[0]), .vsync(vs[0]), .blank_n(bl[0]), .line_start(ls[0]),
    .frame_start(fs[0]), .field(fd[0]));

  video_timing_gen #(
    .H_W(3), .V_W(3), .H_PERIOD(8), .H_SYNC_BEGIN(5), .H_SYNC_END(7),
    .H_VALID_BEGIN(1), .H_VALID_END(4), .V_PERIOD(4), .V_SYNC_BEGIN(2),
    .V_SYNC_END(3), .V_VALID_BEGIN(0), .V_VALID_END(3), .HSYNC_ACTIVE_HIGH(0),
    .VSYNC_ACTIVE_HIGH(0), .DELAY(0), .INTERLACE(0)
  ) u1 (
    .clk(clk), .rst(rst), .pix_en(pe[1]), .hcount(hc1), .vcount(vc1),
    .hsync(hs[1]), .vsync(vs[1]), .blank_n(bl[1]), .line_start(ls[1]),
    .frame_start(fs[1]), .field(fd[1]));

  video_timing_gen #(
    .H_W(3), .V_W(3), .H_PERIOD(8), .H_SYNC_BEGIN(5), .H_SYNC_END(7),
    .H_VALID_BEGIN(1), .H_VALID_END(4), .V_PERIOD(4), .V_SYNC_BEGIN(2),
    .V_SYNC_END(3), .V_VALID_BEGIN(0), .V_VALID_END(3), .HSYNC_ACTIVE_HIGH(0),
    .VSYNC_ACTIVE_HIGH(0), .DELAY(2), .INTERLACE(0)
  ) u2 (
    .clk(clk), .rst(rst), .pix_en(pe[2]), .hcount(hc2), .vcount(vc2),
    .hsync(hs[2]), .vsync(vs[2]), .blank_n(bl[2]), .line_start(ls[2]),
    .frame_start(fs[2]), .field(fd[2]));

  video_timing_gen #(
    .H_W(3), .V_W(3), .H_PERIOD(8), .H_SYNC_BEGIN(5), .H_SYNC_END(7),
    .H_VALID_BEGIN(1), .H_VALID_END(4), .V_PERIOD(4), .V_SYNC_BEGIN(2),
    .V_SYNC_END(2), .V_VALID_BEGIN(0), .V_VALID_END(3), .HSYNC_ACTIVE_HIGH(0),
    .VSYNC_ACTIVE_HIGH(1), .DELAY(0), .INTERLACE(1)
  ) u3 (
    .clk(clk), .rst(rst), .pix_en(pe[3]), .hcount(hc3), .vcount(vc3),
    .hsync(hs[3]), .vsync(vs[3]), .blank_n(bl[3]), .line_start(ls[3]),
    .frame_start(fs[3]), .field(fd[3]));

  always_comb begin
    hcnt[0] = 32'(hc0); vcnt[0] = 32'(vc0);
    hcnt[1] = 32'(hc1); vcnt[1] = 32'(vc1);
    hcnt[2] = 32'(hc2); vcnt[2] = 32'(vc2);
    hcnt[3] = 32'(hc3); vcnt[3] = 32'(vc3);
  end

  // Pixel index since reset, per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) k[i] <= 0;
      else if (pe[i]) k[i] <= k[i] + 1;
    end
  end

  // Raster position of pixel n: lines are whole, an interlaced frame pair is
  // an even field of vp lines followed by an odd field of vp+1 lines.
  function automatic void pos(input cfg_t c, input int n, output int h, output int v,
                              output int f);
    int pair, o;
    h = n % c.hp;
    if (c.il != 0) begin
      pair = c.hp * (2 * c.vp + 1);
      o = n % pair;
      if (o < c.hp * c.vp) begin
        f = 0; v = o / c.hp;
      end else begin
        f = 1; v = (o - c.hp * c.vp) / c.hp;
      end
    end else begin
      f = 0; v = (n / c.hp) % c.vp;
    end
  endfunction

  // Expected {hsync,vsync,blank_n,line_start,frame_start,field} after n strobes.
  function automatic logic [5:0] exp_out(input cfg_t c, input int n);
    int h, v, f;
    logic ha, va, hsv, vsv, blk;
    if (n < 1 + c.dly) return {(c.hah == 0), (c.vah == 0), 4'b0000};
    pos(c, n - 1 - c.dly, h, v, f);
    ha  = (h >= c.hsb) && (h < c.hse);
    va  = (v >= c.vsb) && (v < c.vse);
    hsv = (c.hah != 0) ? ha : !ha;
    vsv = (c.vah != 0) ? va : !va;
    blk = (h >= c.hvb) && (h < c.hve) && (v >= c.vvb) && (v < c.vve);
    return {hsv, vsv, blk, (h == 0), (h == 0) && (v == 0), (f != 0)};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Every cycle after the first reset edge, compare all instances with the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        int eh, ev, ef;
        logic [5:0] got, want;
        pos(cfgs[i], k[i], eh, ev, ef);
        got  = {hs[i], vs[i], bl[i], ls[i], fs[i], fd[i]};
        want = exp_out(cfgs[i], k[i]);
        n_tests++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL u%0d_outputs k=%0d: got %b, expected %b", i, k[i], got, want);
        end
        n_tests++;
        if (hcnt[i] !== 32'(eh) || vcnt[i] !== 32'(ev)) begin
          n_fail++;
          $display("FAIL u%0d_counters k=%0d: got h=%0d v=%0d, expected h=%0d v=%0d",
                   i, k[i], hcnt[i], vcnt[i], eh, ev);
        end
      end
    end
  end

  int fs_at [$];
  int fd_at [$];
  int exp_fs [6] = '{1, 33, 73, 105, 145, 177};
  logic vs_seen = 1'b0;

  initial begin
    cfgs[0] = '{64, 56, 61, 3, 53, 260, 251, 254, 8, 248, 0, 0, 0, 0};
    cfgs[1] = '{8, 5, 7, 1, 4, 4, 2, 3, 0, 3, 0, 0, 0, 0};
    cfgs[2] = '{8, 5, 7, 1, 4, 4, 2, 3, 0, 3, 0, 0, 2, 0};
    cfgs[3] = '{8, 5, 7, 1, 4, 4, 2, 2, 0, 3, 0, 1, 0, 1};

    // Reset held for 5 clocks with strobes running.
    rst = 1'b1; pe = 4'b1111;
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_hcount", hc0, 0);
    check("rst_vcount", vc0, 0);
    check("rst_hsync", hs[0], 1);
    check("rst_vsync", vs[0], 1);
    check("rst_blank", bl[0], 0);
    check("rst_line_start", ls[0], 0);
    check("rst_frame_start", fs[0], 0);

    // Continuous strobes on u0/u1/u3, one clock in three on u2.
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      pe = {1'b1, (c % 3 == 0), 1'b1, 1'b1};
      @(posedge clk); #1;
      if (c == 0) check("u1_line_start_s1", ls[1], 1);
      if (c == 2) begin
        check("u1_hcount_s3", hc1, 3);
        check("u1_blank_s3", bl[1], 1);
      end
      if (c == 4) check("u1_hsync_s5", hs[1], 1);
      if (c == 5) check("u1_hsync_s6", hs[1], 0);
      if (c == 6) check("u1_hsync_s7", hs[1], 0);
      if (c == 8) check("u1_line_start_s9", ls[1], 1);
      if (c == 6) check("u2_line_start_s3", ls[2], 1);
      if (c == 7) check("u2_line_start_hold", ls[2], 1);
      if (c == 9) check("u2_line_start_s4", ls[2], 0);
      if (c == 18) check("u2_hsync_s7", hs[2], 1);
      if (c == 21) check("u2_hsync_s8", hs[2], 0);
      if (fs[3]) begin
        fs_at.push_back(c + 1);
        fd_at.push_back(int'(fd[3]));
      end
      if (vs[3]) vs_seen = 1'b1;
    end

    check("u3_frame_count", fs_at.size(), 6);
    for (int j = 0; j < 6; j++) begin
      if (j < fs_at.size()) begin
        check($sformatf("u3_frame_start_%0d", j), fs_at[j], exp_fs[j]);
        check($sformatf("u3_field_%0d", j), fd_at[j], j % 2);
      end
    end
    check("u3_vsync_never_active", int'(vs_seen), 0);

    // Walk u1 to h=5, v=3, pause strobes, then reset mid-frame.
    pe = 4'b1111;
    for (int i = 0; i < 64 && (k[1] % 32) != 29; i++) begin
      @(posedge clk); #1;
    end
    pe = 4'b0000;
    @(posedge clk); #1;
    check("u1_pre_rst_hcount", hc1, 5);
    check("u1_pre_rst_vcount", vc1, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_hcount", hc1, 0);
    check("midrst_vcount", vc1, 0);
    check("midrst_hsync", hs[1], 1);
    check("midrst_vsync", vs[1], 1);
    check("midrst_blank", bl[1], 0);
    check("midrst_line_start", ls[1], 0);
    check("midrst_frame_start", fs[1], 0);
    check("midrst_field", fd[1], 0);
    rst = 1'b0; pe = 4'b1111;
    @(posedge clk); #1;
    check("post_rst_hcount", hc1, 1);
    check("post_rst_vcount", vc1, 0);
    check("post_rst_frame_start", fs[1], 1);
    check("post_rst_line_start", ls[1], 1);
    check("post_rst_blank", bl[1], 0);
    repeat (40) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator that replaces the fixed-constant sync/blank decode in the video path.
- Owns its own horizontal and vertical counters and advances them on a pixel-clock enable.
- Decodes sync and valid windows from parameters and applies per-output polarity.
- Delays all timing outputs by a configurable number of pixels so they align with RGB pipeline latency.
- Adds line/frame start strobes and an optional interlace field flag for the NTSC encoder.

Parameters:
- H_W, 6: width of horizontal counter.
- V_W, 9: width of vertical counter.
- H_PERIOD, 64: pixels per line.
- H_SYNC_BEGIN, 56: first h of hsync, inclusive.
- H_SYNC_END, 61: end of hsync, exclusive.
- H_VALID_BEGIN, 3: first active h, inclusive.
- H_VALID_END, 53: end of active h, exclusive.
- V_PERIOD, 260: lines per field (even field).
- V_SYNC_BEGIN, 251: first vsync line, inclusive.
- V_SYNC_END, 254: end of vsync, exclusive.
- V_VALID_BEGIN, 8: first active line, inclusive.
- V_VALID_END, 248: end of active lines, exclusive.
- HSYNC_ACTIVE_HIGH, 0: 1 means hsync is high when active.
- VSYNC_ACTIVE_HIGH, 0: 1 means vsync is high when active.
- DELAY, 0: extra output pipeline stages, counted in pixel strobes, range 0..15.
- INTERLACE, 0: 1 means the odd field has V_PERIOD+1 lines and field toggles.

Ports:
- clk  in  1  system clock (12 MHz domain).
- rst  in  1  synchronous active-high reset.
- pix_en  in  1  pixel strobe; all state advances only when high.
- hcount  out  H_W  current horizontal count, undelayed.
- vcount  out  V_W  current vertical count, undelayed.
- hsync  out  1  delayed hsync, polarity per HSYNC_ACTIVE_HIGH.
- vsync  out  1  delayed vsync, polarity per VSYNC_ACTIVE_HIGH.
- blank_n  out  1  delayed; high when both h and v are inside their valid windows.
- line_start  out  1  delayed; high for the pixel period reflecting h==0.
- frame_start  out  1  delayed; high for the pixel period reflecting h==0, v==0.
- field  out  1  delayed field flag (0 = even field).

Behaviour:
Clocking and reset:
- One clock, clk. Reset is synchronous and active-high on rst.
- rst has priority over pix_en and takes effect on the next clk edge regardless of pix_en or counter position, including mid-line and mid-frame.

Reset values:
- hcount=0, vcount=0, internal field=0.
- All delay-stage registers at inactive levels.
- Outputs: hsync=!HSYNC_ACTIVE_HIGH, vsync=!VSYNC_ACTIVE_HIGH, blank_n=0, line_start=0, frame_start=0, field=0.

Counters (advance only on a clk edge with pix_en=1):
- hcount increments. At H_PERIOD-1 it wraps to 0 and vcount advances.
- vcount wraps to 0 after its last line, and field toggles at that wrap when INTERLACE=1.
- Last line is V_PERIOD-1 when field=0. When field=1 and INTERLACE=1 it is V_PERIOD.
- With INTERLACE=0, field stays 0.
- Widths: H_W must hold H_PERIOD-1 and V_W must hold V_PERIOD (checked at elaboration).

Decode stage (registered, updates only on pix_en):
- Windows are half-open: active when BEGIN <= count < END.
- If BEGIN >= END the window is never active; no wrap-around windows.
- Polarity is applied at decode.
- line_start = (h==0); frame_start = (h==0 && v==0).

Delay line:
- DELAY registers follow the decode stage, shifting only on pix_en.
- DELAY=0 means decode registers drive the outputs directly.

Latency and hold:
- Output values reflecting counter state (h,v) appear after 1+DELAY pix_en strobes.
- When pix_en=0, every output holds its value.
- hcount/vcount are raw counter state with no added latency.

Back-to-back and gapped strobes:
- pix_en high on every clk is legal.
- Arbitrary gaps are legal. Timing in pixels is independent of gap pattern.

Test Plan:
- Reset hold: rst=1 for 5 clks with pix_en=1 -> hcount=0, vcount=0, hsync=1, vsync=1 (active-low defaults), blank_n=0, strobes 0 throughout.
- H decode: H_PERIOD=8, H_SYNC 5..7, H_VALID 1..4, DELAY=0, pix_en continuous after reset -> after strobe k, outputs reflect h=(k-1) mod 8. hsync=0 after strobes 6,7; blank_n=1 (when v valid) after strobes 2,3,4; line_start=1 after strobes 1,9,17.
- Delay and gaps: same config with DELAY=2 and pix_en high 1 clk in 3 -> every output pattern shifts by exactly 2 strobes; outputs are constant across non-strobe clks.
- Interlace: H_PERIOD=8, V_PERIOD=4, INTERLACE=1 -> frame_start separations alternate 32 and 40 strobes; field toggles with each frame_start; vcount reaches 4 only when field=1.
- Degenerate window and polarity: V_SYNC_BEGIN=V_SYNC_END=2, VSYNC_ACTIVE_HIGH=1 -> vsync constantly 0 over 3 full frames.
- Mid-frame reset: assert rst at h=5, v=3 with pix_en=0 -> next clk all outputs and counters at reset values; after release, first strobe yields hcount=1 and outputs reflecting h=0, v=0 with frame_start=1.
